// File: rtl/fpu_round_pkg.sv
// Shared rounding-mode encoding, fraction-width constants and flag payload.
// Optional feature macro: FMA_ROUND_RMM_EN (enables frm=100 round-to-max-magnitude).
package fpu_round_pkg;

    // frm encoding
    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } frm_e;

    // Fraction widths of the supported formats
    localparam int unsigned NF_HALF   = 10;
    localparam int unsigned NF_SINGLE = 23;
    localparam int unsigned NF_DOUBLE = 52;

    // Flags travelling alongside the result fraction
    typedef struct packed {
        logic postnormalize;
        logic infinity;
        logic specialsel;
        logic inexact;
        logic illegal_rm;
    } round_flags_t;

endpackage

// File: rtl/fma_round_core.sv
// Combinational rounding, special-result selection and flag generation.
// Optional feature macro: FMA_ROUND_RMM_EN (frm=100 becomes a legal RMM mode).
module fma_round_core
    import fpu_round_pkg::*;
#(
    parameter int unsigned NF = NF_DOUBLE
) (
    input  logic [NF+1:0] v,
    input  logic [2:0]    frm,
    input  logic          wsign,
    input  logic          invalid,
    input  logic          overflow,
    input  logic          underflow,
    input  logic          inf,
    input  logic          nan,
    input  logic          xnan,
    input  logic          ynan,
    input  logic          znan,
    input  logic [NF-1:0] x,
    input  logic [NF-1:0] y,
    input  logic [NF-1:0] z,
    input  logic [NF-1:0] earlyres,
    input  logic          earlyressel,
    output logic [NF-1:0] w_c,
    output round_flags_t  flags_c
);

    localparam logic [NF-1:0] QNAN_BIT = {1'b1, {(NF-1){1'b0}}};

    logic          lsb;
    logic          grd;
    logic          stk;
    logic          rne;
    logic          rdn;
    logic          rup;
    logic          rmm;
    logic          illegal_rm;
    logic          plus1;
    logic          specialsel;
    logic [NF-1:0] rounded;
    logic [NF-1:0] qnan;

    assign lsb = v[2];
    assign grd = v[1];
    assign stk = v[0];

    // Mode decode; illegal encodings leave every mode bit low, i.e. behave as RTZ
    always_comb begin
        rne = (frm == RNE);
        rdn = (frm == RDN);
        rup = (frm == RUP);
`ifdef FMA_ROUND_RMM_EN
        rmm        = (frm == RMM);
        illegal_rm = (frm > RMM);
`else
        rmm        = 1'b0;
        illegal_rm = frm[2];
`endif
    end

    // Round increment and rounded fraction (wraps to zero on carry-out)
    always_comb begin
        plus1 = (rne & grd & (stk | lsb))
              | (rdn & wsign & (grd | stk))
              | (rup & ~wsign & (grd | stk))
              | (rmm & grd);
        rounded = v[NF+1:2] + NF'(plus1);
    end

    // Quiet NaN payload from the first NaN operand, MSB forced high
    always_comb begin
        if (xnan)      qnan = x | QNAN_BIT;
        else if (ynan) qnan = y | QNAN_BIT;
        else if (znan) qnan = z | QNAN_BIT;
        else           qnan = QNAN_BIT;
    end

    assign specialsel = earlyressel | invalid | nan | overflow | underflow | inf;

    // Result fraction with special-case priority
    always_comb begin
        w_c = rounded;
        if (earlyressel)           w_c = earlyres;
        else if (invalid | nan)    w_c = qnan;
        else if (overflow)         w_c = flags_c.infinity ? '0 : '1;
        else if (inf | underflow)  w_c = '0;
    end

    // Flag bundle
    always_comb begin
        flags_c               = '0;
        flags_c.postnormalize = (&v[NF+1:2]) & plus1;
        flags_c.infinity      = rne | rmm | (rup & ~wsign) | (rdn & wsign);
        flags_c.specialsel    = specialsel;
        flags_c.inexact       = (~specialsel & (grd | stk))
                              | (overflow & ~earlyressel & ~invalid & ~nan);
        flags_c.illegal_rm    = illegal_rm;
    end

endmodule

// File: rtl/fma_round_pipe.sv
// FMA rounding stage: combinational core followed by STAGES stall-able registers.
// Optional feature macro: FMA_ROUND_RMM_EN (enables RMM rounding in the core).
module fma_round_pipe
    import fpu_round_pkg::*;
#(
    parameter int unsigned NF     = NF_DOUBLE,
    parameter int unsigned STAGES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NF+1:0] v,
    input  logic [2:0]    frm,
    input  logic          wsign,
    input  logic          invalid,
    input  logic          overflow,
    input  logic          underflow,
    input  logic          inf,
    input  logic          nan,
    input  logic          xnan,
    input  logic          ynan,
    input  logic          znan,
    input  logic [NF-1:0] x,
    input  logic [NF-1:0] y,
    input  logic [NF-1:0] z,
    input  logic [NF-1:0] earlyres,
    input  logic          earlyressel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NF-1:0] w,
    output logic          postnormalize,
    output logic          infinity,
    output logic          specialsel,
    output logic          inexact,
    output logic          illegal_rm
);

    logic [NF-1:0] w_c;
    round_flags_t  flags_c;
    logic          advance;

    logic          vld_q  [STAGES];
    logic [NF-1:0] w_q    [STAGES];
    round_flags_t  flags_q[STAGES];

    fma_round_core #(.NF(NF)) u_core (
        .v           (v),
        .frm         (frm),
        .wsign       (wsign),
        .invalid     (invalid),
        .overflow    (overflow),
        .underflow   (underflow),
        .inf         (inf),
        .nan         (nan),
        .xnan        (xnan),
        .ynan        (ynan),
        .znan        (znan),
        .x           (x),
        .y           (y),
        .z           (z),
        .earlyres    (earlyres),
        .earlyressel (earlyressel),
        .w_c         (w_c),
        .flags_c     (flags_c)
    );

    // Whole pipeline moves together; bubbles are kept, not collapsed
    assign advance  = out_ready | ~vld_q[STAGES-1];
    assign in_ready = advance;

    // Stage registers with per-stage valid bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_q[i]   <= 1'b0;
                w_q[i]     <= '0;
                flags_q[i] <= '0;
            end
        end else if (advance) begin
            vld_q[0]   <= in_valid;
            w_q[0]     <= w_c;
            flags_q[0] <= flags_c;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i]   <= vld_q[i-1];
                w_q[i]     <= w_q[i-1];
                flags_q[i] <= flags_q[i-1];
            end
        end
    end

    assign out_valid     = vld_q[STAGES-1];
    assign w             = w_q[STAGES-1];
    assign postnormalize = flags_q[STAGES-1].postnormalize;
    assign infinity      = flags_q[STAGES-1].infinity;
    assign specialsel    = flags_q[STAGES-1].specialsel;
    assign inexact       = flags_q[STAGES-1].inexact;
    assign illegal_rm    = flags_q[STAGES-1].illegal_rm;

endmodule

// File: tb/tb_fma_round_pipe.sv
// Directed bench for fma_round_pipe (NF=52, STAGES=2); honours FMA_ROUND_RMM_EN.
module tb_fma_round_pipe;

    localparam int unsigned NF     = 52;
    localparam int unsigned STAGES = 2;
    localparam logic [NF-1:0] ONES = {NF{1'b1}};
    localparam logic [NF-1:0] QNB  = {1'b1, {(NF-1){1'b0}}};

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [NF+1:0] v;
    logic [2:0]    frm;
    logic          wsign, invalid, overflow, underflow, inf, nan;
    logic          xnan, ynan, znan;
    logic [NF-1:0] x, y, z, earlyres;
    logic          earlyressel;
    logic          out_valid;
    logic          out_ready;
    logic [NF-1:0] w;
    logic          postnormalize, infinity, specialsel, inexact, illegal_rm;

    int errors = 0;
    int checks = 0;

    // flags packed as {postnormalize, infinity, specialsel, inexact, illegal_rm}
    typedef struct {
        string         name;
        logic [NF+1:0] v;
        logic [2:0]    frm;
        logic          wsign;
        logic [4:0]    exc;   // {invalid, overflow, underflow, inf, nan}
        logic [2:0]    nans;  // {xnan, ynan, znan}
        logic [NF-1:0] x, y, z, er;
        logic          ers;
        logic [NF-1:0] exp_w;
        logic [4:0]    exp_fl;
    } vec_t;

    vec_t vecs[$];

    fma_round_pipe #(.NF(NF), .STAGES(STAGES)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .v(v), .frm(frm), .wsign(wsign), .invalid(invalid), .overflow(overflow),
        .underflow(underflow), .inf(inf), .nan(nan), .xnan(xnan), .ynan(ynan),
        .znan(znan), .x(x), .y(y), .z(z), .earlyres(earlyres),
        .earlyressel(earlyressel), .out_valid(out_valid), .out_ready(out_ready),
        .w(w), .postnormalize(postnormalize), .infinity(infinity),
        .specialsel(specialsel), .inexact(inexact), .illegal_rm(illegal_rm)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string name, input logic [NF+1:0] vv,
                                input logic [2:0] f, input logic ws,
                                input logic [4:0] exc, input logic [2:0] nans,
                                input logic [NF-1:0] xx, input logic [NF-1:0] yy,
                                input logic [NF-1:0] zz, input logic [NF-1:0] er,
                                input logic ers, input logic [NF-1:0] ew,
                                input logic [4:0] efl);
        vec_t t;
        t.name = name; t.v = vv; t.frm = f; t.wsign = ws; t.exc = exc; t.nans = nans;
        t.x = xx; t.y = yy; t.z = zz; t.er = er; t.ers = ers;
        t.exp_w = ew; t.exp_fl = efl;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] act_flags();
        return {postnormalize, infinity, specialsel, inexact, illegal_rm};
    endfunction

    task automatic drive(input vec_t t);
        v = t.v; frm = t.frm; wsign = t.wsign;
        {invalid, overflow, underflow, inf, nan} = t.exc;
        {xnan, ynan, znan} = t.nans;
        x = t.x; y = t.y; z = t.z; earlyres = t.er; earlyressel = t.ers;
    endtask

    task automatic drive_plain(input logic [NF-1:0] frac);
        vec_t t;
        t = mk("plain", {frac, 2'b00}, 3'b001, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, 1'b0, frac, 5'b0);
        drive(t);
    endtask

    logic [NF-1:0] exp_q[$];
    int            sent;
    int            got;

    initial begin
        // Vector table: hand-computed expectations
        vecs.push_back(mk("rne_up",    {52'h1, 2'b10}, 3'b000, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, 1'b0, 52'h2, 5'b01010));
        vecs.push_back(mk("rne_tie",   {52'h2, 2'b10}, 3'b000, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, 1'b0, 52'h2, 5'b01010));
        vecs.push_back(mk("rup_carry", {ONES, 2'b01},  3'b011, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, 1'b0, '0, 5'b11010));
        vecs.push_back(mk("rup_neg",   {ONES, 2'b01},  3'b011, 1'b1, 5'b0, 3'b0, '0, '0, '0, '0, 1'b0, ONES, 5'b00010));
        vecs.push_back(mk("ovf_rtz",   {52'h0, 2'b00}, 3'b001, 1'b0, 5'b01000, 3'b0, '0, '0, '0, '0, 1'b0, ONES, 5'b00110));
        vecs.push_back(mk("ovf_rne",   {52'h0, 2'b00}, 3'b000, 1'b0, 5'b01000, 3'b0, '0, '0, '0, '0, 1'b0, '0, 5'b01110));
        vecs.push_back(mk("ynan",      {52'h0, 2'b00}, 3'b000, 1'b0, 5'b00001, 3'b010, '0, 52'h5, '0, '0, 1'b0, 52'h8_0000_0000_0005, 5'b01100));
`ifdef FMA_ROUND_RMM_EN
        vecs.push_back(mk("rmm",       {52'h2, 2'b10}, 3'b100, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, 1'b0, 52'h3, 5'b01010));
`else
        vecs.push_back(mk("rmm_off",   {52'h2, 2'b10}, 3'b100, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, 1'b0, 52'h2, 5'b00011));
`endif
        vecs.push_back(mk("frm111",    {52'h5, 2'b11}, 3'b111, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, 1'b0, 52'h5, 5'b00011));
        vecs.push_back(mk("early",     {52'h0, 2'b10}, 3'b001, 1'b0, 5'b10000, 3'b0, '0, '0, '0, 52'hABC, 1'b1, 52'hABC, 5'b00100));
        vecs.push_back(mk("inv_nonan", {52'h0, 2'b00}, 3'b010, 1'b1, 5'b10000, 3'b0, '0, '0, '0, '0, 1'b0, QNB, 5'b01100));
        vecs.push_back(mk("underflow", {52'h9, 2'b11}, 3'b000, 1'b0, 5'b00100, 3'b0, '0, '0, '0, '0, 1'b0, '0, 5'b01100));
        vecs.push_back(mk("rdn_neg",   {52'h10, 2'b01}, 3'b010, 1'b1, 5'b0, 3'b0, '0, '0, '0, '0, 1'b0, 52'h11, 5'b01010));
        vecs.push_back(mk("xz_nan",    {52'h0, 2'b00}, 3'b001, 1'b0, 5'b00001, 3'b101, 52'h3, '0, 52'h7, '0, 1'b0, 52'h8_0000_0000_0003, 5'b00100));
        vecs.push_back(mk("rtz_trunc", {52'h7, 2'b11}, 3'b001, 1'b0, 5'b0, 3'b0, '0, '0, '0, '0, 1'b0, 52'h7, 5'b00010));
        vecs.push_back(mk("ovf_early", {52'h0, 2'b00}, 3'b000, 1'b0, 5'b01000, 3'b0, '0, '0, '0, 52'h123, 1'b1, 52'h123, 5'b01100));

        // Reset state
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive_plain('0);
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_w", 64'(w), 64'd0);
        chk("rst_flags", 64'(act_flags()), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven: latency and values for each vector
        foreach (vecs[i]) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({vecs[i].name, "_lat"}, 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            chk({vecs[i].name, "_valid"}, 64'(out_valid), 64'd1);
            chk({vecs[i].name, "_w"}, 64'(w), 64'(vecs[i].exp_w));
            chk({vecs[i].name, "_flags"}, 64'(act_flags()), 64'(vecs[i].exp_fl));
            @(posedge clk); #1;
        end

        // Streaming with a 3-cycle downstream stall
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 4);
            drive_plain(52'(sent + 16));
            @(negedge clk);
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                if (exp_q.size() > 0) chk("stall_w_hold", 64'(w), 64'(exp_q[0]));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("stream_extra", 64'(w), 64'hDEAD);
                else chk("stream_order", 64'(w), 64'(exp_q.pop_front()));
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(52'(sent + 16));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", 64'(got), 64'd4);
        repeat (3) begin
            @(negedge clk);
            chk("stream_no_dup", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Reset with two ops in flight
        drive_plain(52'h77); in_valid = 1'b1;
        @(posedge clk); #1;
        drive_plain(52'h78);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("inflight_valid", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_drop_valid", 64'(out_valid), 64'd0);
        chk("rst_drop_w", 64'(w), 64'd0);
        chk("rst_drop_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        drive_plain(52'h99); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_lat", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_w", 64'(w), 64'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fma_round_pipe.md
FMA_ROUND_PIPE -- requirements
Module: fma_round_pipe

Interface
REQ-001 Parameter NF, default 52: fraction width in bits. Legal values are 10, 23 and 52.
REQ-002 Parameter STAGES, default 2: pipeline register depth. Legal values are 1 to 4.
REQ-003 The block has one clock, clk. Reset is asynchronous and active-low, reset_n.
REQ-004 Ports, in order: name, direction, width, meaning.
- clk, in, 1: clock.
- reset_n, in, 1: async active-low reset.
- in_valid, in, 1: input operation valid.
- in_ready, out, 1: block can accept an input.
- v, in, NF+2: normalized fraction; v[1]=G (round bit), v[0]=S (sticky).
- frm, in, 3: rounding mode. 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- wsign, in, 1: result sign.
- invalid, overflow, underflow, inf, nan, in, 1 each: exception classes.
- xnan, ynan, znan, in, 1 each: operand is NaN.
- x, y, z, in, NF each: operand fractions.
- earlyres, in, NF: result from another FPU unit.
- earlyressel, in, 1: select earlyres.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- w, out, NF: rounded or special fraction.
- postnormalize, out, 1: rounding carried out of the fraction.
- infinity, out, 1: overflow produces infinity (not max-finite).
- specialsel, out, 1: w is a special result.
- inexact, out, 1: NX flag.
- illegal_rm, out, 1: frm is not supported.

Function
REQ-005 Let L=v[2]. plus1 is: RNE G&(S|L); RTZ 0; RDN wsign&(G|S); RUP ~wsign&(G|S); RMM G. plus1 is 0 whenever illegal_rm is 1.
REQ-006 illegal_rm=1 for frm values 101, 110 and 111, and for frm 100 when RMM is compiled out. In that case rounding behaves as RTZ.
REQ-007 postnormalize = (&v[NF+1:2]) & plus1. The rounded fraction is (v[NF+1:2]+plus1) truncated to NF bits, so it is all-zero on carry-out.
REQ-008 specialsel = earlyressel|invalid|nan|overflow|underflow|inf.
REQ-009 Special-result priority, highest first:
- earlyressel: earlyres.
- invalid or nan: quiet NaN. The payload comes from the first NaN operand in the order x, y, z, with its MSB forced to 1. With no NaN operand the result is {1,0...}.
- overflow: all-zeros if infinity, else all-ones.
- inf or underflow: zero.
REQ-010 infinity = RNE|RMM|(RUP&~wsign)|(RDN&wsign), using the RTZ interpretation when illegal_rm is 1.
REQ-011 inexact = (~specialsel&(G|S)) | (overflow&~earlyressel&~invalid&~nan).
REQ-012 The result and all flags are computed combinationally from the inputs. They then travel through STAGES register stages, each holding its own valid bit.
REQ-013 Latency is exactly STAGES cycles from the accepting edge (in_valid&in_ready) to out_valid, when out_ready is held at 1.
REQ-014 Stall: advance = out_ready|~out_valid, and in_ready = advance. When advance=0, every stage holds its data and valid bit.
REQ-015 When advance=1 and in_valid=0, a bubble (valid=0) enters stage 1. Bubbles are not collapsed.
REQ-016 Throughput is one operation per cycle while out_ready=1.
REQ-017 Output data is stable and unchanged while out_valid&~out_ready.
REQ-018 When in_valid, out_valid and out_ready are all 1 in the same cycle, the transfer out and the acceptance in both happen on that edge.

Reset
REQ-019 While reset_n=0, all valid bits and all data registers clear to 0 asynchronously.
REQ-020 While reset_n=0: out_valid=0, w=0, and every flag output is 0. in_ready=1, because out_valid=0.
REQ-021 Operations in flight when reset is asserted are discarded without any output.
REQ-022 After reset_n rises, the first accepted operation appears exactly STAGES cycles later.

Configuration
REQ-023 Macro FMA_ROUND_RMM_EN.
- Defined: frm=100 performs round-to-nearest, ties-to-max-magnitude.
- Undefined: frm=100 asserts illegal_rm and rounds as RTZ. No RMM logic is synthesized.

Structure
REQ-024 Package fpu_round_pkg holds the frm encoding enum (RNE, RTZ, RDN, RUP, RMM) and the default-NF constants 10, 23 and 52.
REQ-025 One sub-module, fma_round_core, is purely combinational and parametrised by NF. It implements REQ-005 to REQ-011.
REQ-026 fma_round_pipe instantiates fma_round_core once and owns only the stage registers and the handshake.

Verification
REQ-027 NF=52, STAGES=2, RNE, wsign=0, v={52'h1,G=1,S=0}: after 2 cycles, w=52'h2 and inexact=1. With v={52'h2,1,0}: w=52'h2.
REQ-028 RUP, wsign=0, v={52'hF_FFFF_FFFF_FFFF,0,1}: w=0, postnormalize=1, inexact=1. The same input with wsign=1: w=52'hF_FFFF_FFFF_FFFF, postnormalize=0.
REQ-029 overflow=1, RTZ: w=all-ones, infinity=0, inexact=1. Switch to RNE: w=0, infinity=1. With ynan=1, nan=1 and y=52'h0_0000_0000_0005: w=52'h8_0000_0000_0005.
REQ-030 Stream 4 ops back-to-back and hold out_ready=0 for 3 cycles mid-stream:
- in_ready falls in the cycle out_valid&~out_ready.
- No op is lost or duplicated.
- Output order is preserved and w holds steady during the stall.
REQ-031 frm=100 with v={52'h2,1,0}:
- FMA_ROUND_RMM_EN defined: w=52'h3, illegal_rm=0.
- Undefined: w=52'h2, illegal_rm=1.
- frm=111 with any v: illegal_rm=1.
REQ-032 Assert reset_n=0 with 2 ops in flight:
- out_valid drops immediately and no stale result appears.
- An op accepted after release emerges exactly STAGES cycles later.
